fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the decode signal generator. Holds the program counter, issues word requests to instruction memory over a request/grant + in-order response handshake, buffers returned words with their PC, and presents one instruction per cycle to decode. Branch/jump resolution redirects the PC, flushing buffered and in-flight fetches.

---
 rtl/yarc_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 61 ++++++
 rtl/fetch_unit.sv | 143 ++++++++++++++
 tb/tb_fetch_unit.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/yarc_pkg.sv
// Shared definitions for the yarc front end: data width, NOP encoding,
// fetch state encoding and default reset PC.
package yarc_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST     = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } fetch_state_e;

  // Sequential fetch address; wraps naturally at 2^32.
  function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush, used for the fetch instruction buffer and the
// in-flight PC tag queue. DEPTH must be a power of two.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is accepted when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];
  assign count   = cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, credit-limited imem requests, tagged response
// buffer, redirect flush. Optional feature macro: IFETCH_MISALIGN_CHECK_EN.
module fetch_unit
  import yarc_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
  parameter int              BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
`ifdef IFETCH_MISALIGN_CHECK_EN
  output logic            misalign,
`endif
  output fetch_state_e    state_dbg
);

  // Handshake: a request is accepted in a cycle where imem_req && imem_gnt;
  // each accepted request gets exactly one imem_rvalid later, in order.
  // Decode consumes the head in any cycle where inst_valid && !stall.

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam logic [CNT_W:0] DEPTH_L = (CNT_W+1)'(BUF_DEPTH);

  fetch_state_e      state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic [CNT_W-1:0]  in_flight;
  logic [CNT_W-1:0]  in_flight_nxt;
  logic [CNT_W-1:0]  occ;
  logic [CNT_W:0]    used;
  logic              tag_full, tag_empty;
  logic              buf_full, buf_empty;
  logic [XLEN-1:0]   tag_pc;
  logic [2*XLEN-1:0] buf_head;
  logic              grant, resp, keep, pop;

  assign inst_valid = !buf_empty;
  assign pop        = inst_valid && !stall;
  assign grant      = imem_req && imem_gnt;
  assign resp       = imem_rvalid && !tag_empty;
  assign keep       = resp && (drop_q == '0) && !redirect && (state_q == FETCH)
                      && (!buf_full || pop);
  assign imem_addr  = pc_q;
  assign state_dbg  = state_q;
  assign inst       = buf_empty ? NOP_INST : buf_head[XLEN-1:0];
  assign inst_pc    = buf_empty ? '0 : buf_head[2*XLEN-1:XLEN];

  // The slot vacated by this cycle's pop is reusable, which keeps a
  // 1-cycle-latency memory streaming at one word per cycle.
  always_comb begin
    used     = {1'b0, in_flight} + {1'b0, occ} - {{CNT_W{1'b0}}, pop};
    imem_req = rst && (state_q == FETCH) && !tag_full && (used < DEPTH_L);
    in_flight_nxt = in_flight + CNT_W'(grant) - CNT_W'(resp);
  end

  // Tag count equals the number of outstanding requests, dropped ones included.
  fetch_fifo #(.DEPTH(BUF_DEPTH), .WIDTH(XLEN)) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (1'b0),
    .push  (grant),
    .pop   (resp),
    .wdata (pc_q),
    .rdata (tag_pc),
    .full  (tag_full),
    .empty (tag_empty),
    .count (in_flight)
  );

  fetch_fifo #(.DEPTH(BUF_DEPTH), .WIDTH(2*XLEN)) u_inst_buf (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect),
    .push  (keep),
    .pop   (pop),
    .wdata ({tag_pc, imem_rdata}),
    .rdata (buf_head),
    .full  (buf_full),
    .empty (buf_empty),
    .count (occ)
  );

`ifdef IFETCH_MISALIGN_CHECK_EN
  logic misalign_d;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
`ifdef IFETCH_MISALIGN_CHECK_EN
    misalign_d = misalign;
`endif
    if (grant) pc_d = pc_next(pc_q);
    if (resp && (drop_q != '0)) drop_d = drop_q - CNT_W'(1);
    if (redirect) begin
      // Everything outstanding after this cycle belongs to the old path.
      drop_d = in_flight_nxt;
`ifdef IFETCH_MISALIGN_CHECK_EN
      misalign_d = |redirect_pc[1:0];
      if (|redirect_pc[1:0]) begin
        state_d = HALT;
      end else begin
        state_d = FETCH;
        pc_d    = redirect_pc;
      end
`else
      pc_d = redirect_pc & ~32'h0000_0003;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
    end
  end

`ifdef IFETCH_MISALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) misalign <= 1'b0;
    else      misalign <= misalign_d;
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table for streaming/stall, hand
// sequences for redirect, wraparound, misaligned target and mid-run reset.
module tb_fetch_unit;
  import yarc_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
`ifdef IFETCH_MISALIGN_CHECK_EN
  logic        misalign;
`endif
  fetch_state_e state_dbg;

  fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
`ifdef IFETCH_MISALIGN_CHECK_EN
    .misalign    (misalign),
`endif
    .state_dbg   (state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [31:0] resp_q[$];
  logic [31:0] exp_q[$];
  logic        mem_hold;

  logic        s_req, s_valid, s_gnt, s_rvalid;
  logic [31:0] s_addr, s_inst, s_pc;

  typedef struct {
    logic        stall;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: memory answers (rdata = address), outputs sampled
  // mid-cycle, then advance to 1ns after the next rising edge.
  task automatic cycle();
    if (!mem_hold && resp_q.size() > 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = resp_q.pop_front();
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
    #1;
    s_req    = imem_req;
    s_addr   = imem_addr;
    s_valid  = inst_valid;
    s_inst   = inst;
    s_pc     = inst_pc;
    s_rvalid = imem_rvalid;
    s_gnt    = imem_req && imem_gnt;
    if (s_gnt) resp_q.push_back(imem_addr);
    @(posedge clk);
    #1;
  endtask

  // Runs until n deliveries have been compared against exp_q, or budget expires.
  task automatic expect_stream(input int n, input int budget);
    int got;
    logic [31:0] e;
    got = 0;
    for (int i = 0; i < budget && got < n; i++) begin
      cycle();
      if (s_valid && !stall) begin
        e = exp_q.pop_front();
        check("stream_pc", s_pc, e);
        check("stream_inst", s_inst, e);
        got++;
      end
    end
    if (got < n) begin
      checks++;
      failures++;
      $display("FAIL stream_timeout: got %0d deliveries required %0d", got, n);
      exp_q.delete();
    end
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect    = 1'b1;
    redirect_pc = target;
    cycle();
    redirect    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b0;
    imem_gnt    = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    stall       = 1'b0;
    mem_hold    = 1'b0;

    // {stall, exp_req, exp_addr, exp_valid, exp_pc}
    vecs[0]  = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
    vecs[1]  = '{1'b0, 1'b1, 32'h04, 1'b0, 32'h00};
    vecs[2]  = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h00};
    vecs[3]  = '{1'b0, 1'b1, 32'h0C, 1'b1, 32'h04};
    vecs[4]  = '{1'b0, 1'b1, 32'h10, 1'b1, 32'h08};
    vecs[5]  = '{1'b0, 1'b1, 32'h14, 1'b1, 32'h0C};
    vecs[6]  = '{1'b0, 1'b1, 32'h18, 1'b1, 32'h10};
    vecs[7]  = '{1'b0, 1'b1, 32'h1C, 1'b1, 32'h14};
    vecs[8]  = '{1'b1, 1'b0, 32'h20, 1'b1, 32'h18};
    vecs[9]  = '{1'b1, 1'b0, 32'h20, 1'b1, 32'h18};
    vecs[10] = '{1'b1, 1'b0, 32'h20, 1'b1, 32'h18};
    vecs[11] = '{1'b1, 1'b0, 32'h20, 1'b1, 32'h18};
    vecs[12] = '{1'b1, 1'b0, 32'h20, 1'b1, 32'h18};
    vecs[13] = '{1'b0, 1'b1, 32'h20, 1'b1, 32'h18};
    vecs[14] = '{1'b0, 1'b1, 32'h24, 1'b1, 32'h1C};
    vecs[15] = '{1'b0, 1'b1, 32'h28, 1'b1, 32'h20};
    vecs[16] = '{1'b0, 1'b1, 32'h2C, 1'b1, 32'h24};

    // Reset values
    @(posedge clk);
    #1;
    check("rst_req", imem_req, 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", inst_valid, 32'd0);
    check("rst_inst", inst, NOP_INST);
    check("rst_pc", inst_pc, 32'h0);
    check("rst_state", 32'(state_dbg), 32'(FETCH));
`ifdef IFETCH_MISALIGN_CHECK_EN
    check("rst_misalign", misalign, 32'd0);
`endif
    rst = 1'b1;

    // Streaming from reset, then 5 stall cycles with a full buffer
    for (int i = 0; i < 17; i++) begin
      stall = vecs[i].stall;
      cycle();
      check("vec_req", s_req, vecs[i].exp_req);
      check("vec_addr", s_addr, vecs[i].exp_addr);
      check("vec_valid", s_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) begin
        check("vec_pc", s_pc, vecs[i].exp_pc);
        check("vec_inst", s_inst, vecs[i].exp_pc);
      end
    end
    stall = 1'b0;

    // Redirect with two requests outstanding
    mem_hold = 1'b1;
    cycle();
    cycle();
    check("credit_block", s_req, 32'd0);
    do_redirect(32'h0000_0100);
    mem_hold = 1'b0;
    cycle();
    check("redir_valid", s_valid, 32'd0);
    check("redir_addr", s_addr, 32'h0000_0100);
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    exp_q.push_back(32'h108);
    expect_stream(3, 20);

    // Redirect in a cycle that also has a grant and a response
    do_redirect(32'h0000_0200);
    check("coinc_grant", s_gnt, 32'd1);
    check("coinc_rvalid", s_rvalid, 32'd1);
    cycle();
    check("coinc_valid", s_valid, 32'd0);
    check("coinc_addr", s_addr, 32'h0000_0200);
    exp_q.push_back(32'h200);
    exp_q.push_back(32'h204);
    expect_stream(2, 20);

    // PC wraparound
    do_redirect(32'hFFFF_FFF8);
    exp_q.push_back(32'hFFFF_FFF8);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0000_0000);
    exp_q.push_back(32'h0000_0004);
    expect_stream(4, 20);

    // Misaligned redirect target
`ifdef IFETCH_MISALIGN_CHECK_EN
    do_redirect(32'h0000_0102);
    cycle();
    check("mis_flag", misalign, 32'd1);
    check("mis_req", s_req, 32'd0);
    check("mis_valid", s_valid, 32'd0);
    check("mis_state", 32'(state_dbg), 32'(HALT));
    repeat (3) cycle();
    check("mis_hold_flag", misalign, 32'd1);
    check("mis_hold_req", s_req, 32'd0);
    check("mis_hold_valid", s_valid, 32'd0);
    do_redirect(32'h0000_0200);
    cycle();
    check("mis_clear", misalign, 32'd0);
    check("mis_resume_addr", s_addr, 32'h0000_0200);
    check("mis_resume_state", 32'(state_dbg), 32'(FETCH));
    exp_q.push_back(32'h200);
    exp_q.push_back(32'h204);
    expect_stream(2, 20);
`else
    do_redirect(32'h0000_0102);
    cycle();
    check("align_addr", s_addr, 32'h0000_0100);
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    expect_stream(2, 20);
`endif

    // Reset asserted mid-stream
    rst         = 1'b0;
    imem_rvalid = 1'b0;
    resp_q.delete();
    #1;
    check("mrst_req", imem_req, 32'd0);
    check("mrst_addr", imem_addr, 32'h0);
    check("mrst_valid", inst_valid, 32'd0);
    check("mrst_inst", inst, NOP_INST);
    check("mrst_pc", inst_pc, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    expect_stream(3, 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
